// File: rtl/marquee_pkg.sv
// Shared types for the programmable marquee sequencer: op encodings,
// width helpers and the power-on sequence table pattern.
package marquee_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_OR    = 3'd0,
    OP_AND   = 3'd1,
    OP_XOR   = 3'd2,
    OP_CAT   = 3'd3,
    OP_ADD   = 3'd4,
    OP_SUB   = 3'd5,
    OP_NAND  = 3'd6,
    OP_PASSA = 3'd7
  } op_e;

  // Step pointer width; a single-entry table still gets a 1-bit pointer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int len_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Reset pattern repeats the original fixed marquee: OR, AND, XOR, CAT.
  function automatic op_e reset_op(input int idx);
    case (idx % 4)
      0:       return OP_OR;
      1:       return OP_AND;
      2:       return OP_XOR;
      default: return OP_CAT;
    endcase
  endfunction

endpackage

// File: rtl/marquee_seq_if.sv
// Operand-in / result-out stream bundle for marquee_seq.
// Both sides use valid/ready: a beat transfers on the rising clock edge where
// valid and ready are both high; valid must not depend on ready, and the
// payload is held stable while valid is high and ready is low.
interface marquee_seq_if #(
  parameter int W     = 3,
  parameter int DEPTH = 4
);
  import marquee_pkg::*;

  localparam int PW = ptr_w(DEPTH);

  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  out_data;
  logic [PW-1:0]   out_step;

  // master: operand source and result consumer; slave: the sequencer
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_step
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_step
  );

endinterface

// File: rtl/marquee_alu.sv
// Combinational operator: applies one op code to two W-bit operands and
// produces a 2W-bit result.
module marquee_alu
  import marquee_pkg::*;
#(
  parameter int W = 3
) (
  input  op_e            op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] res
);

  localparam int RW = 2 * W;

  logic        [W:0] sum;
  logic signed [W:0] diff;

  // One extra bit keeps the carry for ADD and the true sign for SUB.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = $signed({1'b0, a}) - $signed({1'b0, b});

  always_comb begin
    res = '0;
    case (op)
      OP_OR:    res = RW'(a | b);
      OP_AND:   res = RW'(a & b);
      OP_XOR:   res = RW'(a ^ b);
      OP_CAT:   res = {a, b};
      OP_ADD:   res = RW'(sum);
      OP_SUB:   res = RW'(diff);
      OP_NAND:  res = RW'(~(a & b));
      OP_PASSA: res = RW'(a);
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/marquee_seq.sv
// Programmable marquee sequencer: each accepted operand pair is combined by the
// op stored at the current step, result registered with one cycle of latency.
// Optional feature macro: MARQUEE_SEQ_HOLD_EN (adds the hold input).
module marquee_seq
  import marquee_pkg::*;
#(
  parameter int W     = 3,
  parameter int DEPTH = 4,
  localparam int PW   = ptr_w(DEPTH),
  localparam int LW   = len_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  marquee_seq_if.slave    bus,
  input  logic            cfg_we,
  input  logic [PW-1:0]   cfg_addr,
  input  logic [OP_W-1:0] cfg_op,
  input  logic            cfg_len_we,
  input  logic [LW-1:0]   cfg_len,
`ifdef MARQUEE_SEQ_HOLD_EN
  input  logic            hold,
`endif
  output logic [PW-1:0]   dbg_ptr,
  output logic [LW-1:0]   dbg_len
);

  op_e             tbl [DEPTH];
  logic [PW-1:0]   ptr;
  logic [LW-1:0]   len;
  logic            out_valid;
  logic [2*W-1:0]  out_data;
  logic [PW-1:0]   out_step;

  logic            accept;
  logic            advance;
  logic            ptr_last;
  logic            addr_ok;
  op_e             cur_op;
  logic [2*W-1:0]  alu_res;

  assign bus.in_ready  = !out_valid || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_step  = out_step;
  assign dbg_ptr       = ptr;
  assign dbg_len       = len;

`ifdef MARQUEE_SEQ_HOLD_EN
  assign advance = accept && !hold;
`else
  assign advance = accept;
`endif

  assign ptr_last = (32'(ptr) == 32'(len) - 1);
  assign addr_ok  = (32'(cfg_addr) < DEPTH);

  // Table is read before any same-cycle write lands, so the accept sees the old op.
  assign cur_op = tbl[ptr];

  marquee_alu #(.W(W)) u_alu (
    .op  (cur_op),
    .a   (bus.in_a),
    .b   (bus.in_b),
    .res (alu_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_step  <= '0;
      ptr       <= '0;
      len       <= LW'(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= reset_op(i);
      end
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= alu_res;
        out_step  <= ptr;
      end else if (bus.out_ready) begin
        out_valid <= 1'b0;
      end

      if (cfg_we && addr_ok) begin
        tbl[cfg_addr] <= op_e'(cfg_op);
      end

      // A length write restarts the sequence and overrides any pointer advance.
      if (cfg_len_we) begin
        if (cfg_len == '0 || 32'(cfg_len) > DEPTH) begin
          len <= LW'(DEPTH);
        end else begin
          len <= cfg_len;
        end
        ptr <= '0;
      end else if (advance) begin
        ptr <= ptr_last ? '0 : ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_marquee_seq.sv
// Directed bench for marquee_seq: hand-computed vectors checked with immediate assertions.
module tb_marquee_seq;
  import marquee_pkg::*;

  localparam int W     = 3;
  localparam int DEPTH = 4;
  localparam int PW    = 2;
  localparam int LW    = 3;

  logic            clk;
  logic            rst;
  logic            cfg_we;
  logic [PW-1:0]   cfg_addr;
  logic [2:0]      cfg_op;
  logic            cfg_len_we;
  logic [LW-1:0]   cfg_len;
`ifdef MARQUEE_SEQ_HOLD_EN
  logic            hold;
`endif
  logic [PW-1:0]   dbg_ptr;
  logic [LW-1:0]   dbg_len;

  int n_checks;
  int n_errors;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_v;

  marquee_seq_if #(.W(W), .DEPTH(DEPTH)) bus ();

  marquee_seq #(.W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_op     (cfg_op),
    .cfg_len_we (cfg_len_we),
    .cfg_len    (cfg_len),
`ifdef MARQUEE_SEQ_HOLD_EN
    .hold       (hold),
`endif
    .dbg_ptr    (dbg_ptr),
    .dbg_len    (dbg_len)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand beat for a single cycle.
  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [2*W-1:0] data, input logic [PW-1:0] step);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_data"},  32'(bus.out_data),  32'(data));
    check({tag, "_step"},  32'(bus.out_step),  32'(step));
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    cfg_we        = 1'b0;
    cfg_addr      = '0;
    cfg_op        = '0;
    cfg_len_we    = 1'b0;
    cfg_len       = '0;
`ifdef MARQUEE_SEQ_HOLD_EN
    hold          = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_step",  32'(bus.out_step),  32'd0);
    check("rst_ptr",       32'(dbg_ptr),       32'd0);
    check("rst_len",       32'(dbg_len),       32'd4);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);

    // 1: default table OR,AND,XOR,CAT with A=101 B=011, back-to-back beats
    exp_q.push_back(6'b000111);
    exp_q.push_back(6'b000001);
    exp_q.push_back(6'b000110);
    exp_q.push_back(6'b101011);
    exp_q.push_back(6'b000111);
    bus.in_valid = 1'b1;
    bus.in_a     = 3'b101;
    bus.in_b     = 3'b011;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      expect_out($sformatf("t1_beat%0d", i), exp_v, PW'(i % 4));
    end
    bus.in_valid = 1'b0;
    tick();
    check("t1_drain_valid", 32'(bus.out_valid), 32'd0);
    check("t1_ptr", 32'(dbg_ptr), 32'd1);

    // 2: table[0]=ADD, table[1]=SUB, len=2
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_op = 3'd4;
    tick();
    cfg_addr = 2'd1; cfg_op = 3'd5;
    tick();
    cfg_we = 1'b0;
    cfg_len_we = 1'b1; cfg_len = 3'd2;
    tick();
    cfg_len_we = 1'b0;
    check("t2_len", 32'(dbg_len), 32'd2);
    check("t2_ptr", 32'(dbg_ptr), 32'd0);
    beat(3'd5, 3'd3); expect_out("t2_add0", 6'b001000, 2'd0);
    beat(3'd5, 3'd3); expect_out("t2_sub1", 6'b000010, 2'd1);
    beat(3'd5, 3'd3); expect_out("t2_add2", 6'b001000, 2'd0);
    beat(3'd3, 3'd5); expect_out("t2_subneg", 6'b111110, 2'd1);

    // write to the entry being read in the same cycle: old op (ADD) still used
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_op = 3'd2;
    beat(3'd5, 3'd3);
    cfg_we = 1'b0;
    expect_out("t2_wr_old", 6'b001000, 2'd0);
    beat(3'd5, 3'd3); expect_out("t2_after_sub", 6'b000010, 2'd1);
    beat(3'd5, 3'd3); expect_out("t2_wr_new", 6'b000110, 2'd0);

    // restore len=4 (table now XOR,SUB,XOR,CAT)
    cfg_len_we = 1'b1; cfg_len = 3'd4;
    tick();
    cfg_len_we = 1'b0;
    check("t2_ptr_clr", 32'(dbg_ptr), 32'd0);

    // 3: backpressure holds the result and the pointer
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 3'd5;
    bus.in_b      = 3'd3;
    tick();
    expect_out("t3_first", 6'b000110, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t3_in_ready%0d", i), 32'(bus.in_ready), 32'd0);
      expect_out($sformatf("t3_hold%0d", i), 6'b000110, 2'd0);
      check($sformatf("t3_ptr%0d", i), 32'(dbg_ptr), 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    expect_out("t3_release", 6'b000010, 2'd1);
    tick();
    check("t3_clear_valid", 32'(bus.out_valid), 32'd0);
    check("t3_ptr_after", 32'(dbg_ptr), 32'd2);

    // 4: length write coincides with an accept at ptr=2
    cfg_len_we = 1'b1; cfg_len = 3'd3;
    beat(3'd5, 3'd3);
    cfg_len_we = 1'b0;
    expect_out("t4_same_cycle", 6'b000110, 2'd2);
    check("t4_len", 32'(dbg_len), 32'd3);
    check("t4_ptr", 32'(dbg_ptr), 32'd0);
    beat(3'd6, 3'd3); expect_out("t4_step0", 6'b000101, 2'd0);
    beat(3'd6, 3'd3); expect_out("t4_step1", 6'b000011, 2'd1);
    beat(3'd6, 3'd3); expect_out("t4_step2", 6'b000101, 2'd2);
    check("t4_wrap", 32'(dbg_ptr), 32'd0);
    cfg_len_we = 1'b1; cfg_len = 3'd0;
    tick();
    check("t4_len0", 32'(dbg_len), 32'd4);
    cfg_len = 3'd5;
    tick();
    cfg_len_we = 1'b0;
    check("t4_len5", 32'(dbg_len), 32'd4);

    // 5: reset while a result is stalled
    bus.out_ready = 1'b0;
    beat(3'd1, 3'd2);
    expect_out("t5_pending", 6'b000011, 2'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_valid", 32'(bus.out_valid), 32'd0);
    check("t5_data",  32'(bus.out_data),  32'd0);
    check("t5_ptr",   32'(dbg_ptr),       32'd0);
    check("t5_len",   32'(dbg_len),       32'd4);
    bus.out_ready = 1'b1;
    beat(3'b101, 3'b011); expect_out("t5_tbl0", 6'b000111, 2'd0);
    beat(3'b101, 3'b011); expect_out("t5_tbl1", 6'b000001, 2'd1);
    beat(3'b101, 3'b011); expect_out("t5_tbl2", 6'b000110, 2'd2);
    beat(3'b101, 3'b011); expect_out("t5_tbl3", 6'b101011, 2'd3);

`ifdef MARQUEE_SEQ_HOLD_EN
    // 6: hold keeps the pointer on step 1 (AND) for three accepts
    beat(3'b101, 3'b011); expect_out("t6_pre", 6'b000111, 2'd0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      beat(3'b101, 3'b011);
      expect_out($sformatf("t6_hold%0d", i), 6'b000001, 2'd1);
    end
    hold = 1'b0;
    beat(3'b101, 3'b011); expect_out("t6_release", 6'b000001, 2'd1);
    beat(3'b101, 3'b011); expect_out("t6_next", 6'b000110, 2'd2);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
